// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment driver for the BCD multiplier's product.
// A strobe latches the product or error code. The two digits are then shown in
// alternating time slots. Multiplier error codes are shown as readable glyphs.
module bcd_display_scanner #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:7] bcd_in,
   input  logic       load,
   input  logic       blank_lz,
   output logic       load_ack,
   output logic       err,
   output logic [0:6] seg,
   output logic [0:1] an
);

   localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [7:0]       latch_q, latch_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             idx_q,   idx_d;
   logic [6:0]       seg_q,   seg_d;
   logic [1:0]       an_q,    an_d;
   logic             err_q,   err_d;
   logic             ack_q,   ack_d;

   logic [3:0]       tens_c;
   logic [3:0]       units_c;
   logic             tick_c;

   // Segment pattern (a..g, a in the MSB) for a decimal digit
   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      case (d)
         4'd0:    digit_seg = 7'b1111110;
         4'd1:    digit_seg = 7'b0110000;
         4'd2:    digit_seg = 7'b1101101;
         4'd3:    digit_seg = 7'b1111001;
         4'd4:    digit_seg = 7'b0110011;
         4'd5:    digit_seg = 7'b1011011;
         4'd6:    digit_seg = 7'b1011111;
         4'd7:    digit_seg = 7'b1110000;
         4'd8:    digit_seg = 7'b1111111;
         4'd9:    digit_seg = 7'b1111011;
         default: digit_seg = SEG_DASH;
      endcase
   endfunction

   assign tens_c  = latch_d[7:4];
   assign units_c = latch_d[3:0];
   assign tick_c  = (cnt_q == CNT_MAX);

   // Next-state, prescaler/scan and glyph selection; outputs use the
   // post-edge latch and index so a load coincident with a tick shows both
   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      seg_d   = SEG_BLANK;
      an_d    = 2'b00;
      err_d   = 1'b0;
      ack_d   = load;

      if (load) latch_d = bcd_in;

      case (state_q)
         IDLE: begin
            if (load) state_d = SHOW;
         end
         SHOW: begin
            if (tick_c) begin
               cnt_d = '0;
               idx_d = ~idx_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == SHOW) begin
         an_d = idx_d ? 2'b01 : 2'b10;
         if ((tens_c <= 4'd9) && (units_c <= 4'd9)) begin
            seg_d = digit_seg(idx_d ? units_c : tens_c);
            if (!idx_d && blank_lz && (tens_c == 4'd0)) seg_d = SEG_BLANK;
         end else begin
            err_d = 1'b1;
            case (latch_d)
               8'hF0:   seg_d = idx_d ? digit_seg(4'd1) : SEG_E;
               8'h0F:   seg_d = idx_d ? digit_seg(4'd2) : SEG_E;
               8'hFF:   seg_d = SEG_E;
               default: seg_d = SEG_DASH;
            endcase
         end
      end
   end

   // State, latch, prescaler and registered outputs; reset discards a load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         latch_q <= 8'h00;
         cnt_q   <= '0;
         idx_q   <= 1'b0;
         seg_q   <= SEG_BLANK;
         an_q    <= 2'b00;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   assign seg      = seg_q;
   assign an       = an_q;
   assign err      = err_q;
   assign load_ack = ack_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with CLK_DIV=4.
module tb_bcd_display_scanner;

   logic       clk;
   logic       rst_n;
   logic [0:7] bcd_in;
   logic       load;
   logic       blank_lz;
   logic       load_ack;
   logic       err;
   logic [0:6] seg;
   logic [0:1] an;

   int total;
   int bad;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                          S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111,
                          S7 = 7'b1110000, S8 = 7'b1111111, SE = 7'b1001111,
                          SD = 7'b0000001, SB = 7'b0000000;

   bcd_display_scanner #(.CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
      .blank_lz(blank_lz), .load_ack(load_ack), .err(err),
      .seg(seg), .an(an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // One-cycle load strobe; returns at the first displayed cycle
   task automatic do_load(input logic [7:0] v);
      bcd_in = v;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if ({seg, an, err, load_ack} !== 11'b0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d: seg=%b an=%b err=%b ack=%b required all 0",
                     i, seg, an, err, load_ack);
         end
      end
   endtask

   task automatic test_scan();
      logic [6:0] es;
      logic [1:0] ea;
      do_reset();
      blank_lz = 1'b0;
      do_load(8'h56);
      for (int i = 0; i < 16; i++) begin
         ea = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
         es = (((i / 4) % 2) == 0) ? S5 : S6;
         total++;
         if (an !== ea || seg !== es || err !== 1'b0 || load_ack !== (i == 0)) begin
            bad++;
            $display("FAIL scan_56 cyc=%0d: an=%b seg=%b err=%b ack=%b required an=%b seg=%b err=0 ack=%0d",
                     i, an, seg, err, load_ack, ea, es, (i == 0));
         end
         step();
      end
   endtask

   task automatic test_leading_zero();
      logic [6:0] es;
      do_reset();
      blank_lz = 1'b1;
      do_load(8'h07);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) blank_lz = 1'b0;
         if (i < 4)       es = SB;
         else if (i < 8)  es = S7;
         else if (i < 12) es = S0;
         else             es = S7;
         total++;
         if (an !== ((((i / 4) % 2) == 0) ? 2'b10 : 2'b01) || seg !== es || err !== 1'b0) begin
            bad++;
            $display("FAIL leading_zero cyc=%0d: an=%b seg=%b err=%b required seg=%b err=0",
                     i, an, seg, err, es);
         end
         // blank_lz set here is seen by the output register on the next edge
         if (i == 7) blank_lz = 1'b0;
         step();
      end
   endtask

   task automatic test_errors();
      logic [7:0] codes [5];
      logic [6:0] ts [5];
      logic [6:0] us [5];
      logic       ee [5];
      logic [6:0] es;
      codes = '{8'hF0, 8'h0F, 8'hFF, 8'hA3, 8'h81};
      ts    = '{SE, SE, SE, SD, S8};
      us    = '{S1, S2, SE, SD, S1};
      ee    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      blank_lz = 1'b0;
      for (int k = 0; k < 5; k++) begin
         do_reset();
         do_load(codes[k]);
         for (int i = 0; i < 8; i++) begin
            es = (i < 4) ? ts[k] : us[k];
            total++;
            if (an !== ((i < 4) ? 2'b10 : 2'b01) || seg !== es || err !== ee[k]) begin
               bad++;
               $display("FAIL err_code %h cyc=%0d: an=%b seg=%b err=%b required seg=%b err=%b",
                        codes[k], i, an, seg, err, es, ee[k]);
            end
            step();
         end
      end
   endtask

   task automatic test_load_on_tick();
      do_reset();
      blank_lz = 1'b0;
      do_load(8'h12);
      for (int i = 0; i < 3; i++) step();
      total++;
      if (an !== 2'b10 || seg !== S1) begin
         bad++;
         $display("FAIL pre_tick: an=%b seg=%b required an=10 seg=%b", an, seg, S1);
      end
      do_load(8'h34);
      total++;
      if (an !== 2'b01 || seg !== S4 || load_ack !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL load_on_tick: an=%b seg=%b ack=%b err=%b required an=01 seg=%b ack=1 err=0",
                  an, seg, load_ack, err, S4);
      end
      step();
      total++;
      if (an !== 2'b01 || seg !== S4 || load_ack !== 1'b0) begin
         bad++;
         $display("FAIL after_tick_load: an=%b seg=%b ack=%b required an=01 seg=%b ack=0",
                  an, seg, load_ack, S4);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bcd_in = 8'h11;
      load   = 1'b1;
      step();
      total++;
      if (load_ack !== 1'b1 || seg !== S1 || an !== 2'b10) begin
         bad++;
         $display("FAIL b2b_first: ack=%b seg=%b an=%b required ack=1 seg=%b an=10", load_ack, seg, an, S1);
      end
      bcd_in = 8'h22;
      step();
      load = 1'b0;
      total++;
      if (load_ack !== 1'b1 || seg !== S2 || an !== 2'b10) begin
         bad++;
         $display("FAIL b2b_second: ack=%b seg=%b an=%b required ack=1 seg=%b an=10", load_ack, seg, an, S2);
      end
      step();
      total++;
      if (load_ack !== 1'b0 || seg !== S2) begin
         bad++;
         $display("FAIL b2b_end: ack=%b seg=%b required ack=0 seg=%b", load_ack, seg, S2);
      end
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      do_load(8'h56);
      for (int i = 0; i < 4; i++) step();
      total++;
      if (an !== 2'b01 || seg !== S6) begin
         bad++;
         $display("FAIL mid_scan_pre: an=%b seg=%b required an=01 seg=%b", an, seg, S6);
      end
      rst_n  = 1'b0;
      load   = 1'b1;
      bcd_in = 8'h99;
      step();
      rst_n = 1'b1;
      load  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         total++;
         if ({seg, an, err, load_ack} !== 11'b0) begin
            bad++;
            $display("FAIL reset_mid_scan cyc=%0d: seg=%b an=%b err=%b ack=%b required all 0",
                     i, seg, an, err, load_ack);
         end
         step();
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      bcd_in   = 8'h00;
      blank_lz = 1'b0;
      test_reset();
      test_scan();
      test_leading_zero();
      test_errors();
      test_load_on_tick();
      test_back_to_back();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
